hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage MIPS core. Tracks per-stage Tnew/Tuse/A1/A2/A3 for E, M, W.
//  Issues D-stage stall (NOP insert into D/E) and forwarding selects for D and E, and sequences the
//  multi-cycle mult/div unit with a busy counter. Sits beside the D/E, E/M and M/W pipeline registers.
// PARAMETERS
//  MULT_CYC   5   E-stage cycles a mult occupies the MD unit (>=1)
//  DIV_CYC    10  E-stage cycles a div occupies the MD unit (>=1)
// PORTS
//  clk          in   1  core clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  d_a1/d_a2    in   5  D-stage source register numbers
//  d_tuse_a1/a2 in   2  cycles from D until source needed; 3 = source unused
//  d_a3         in   5  D-stage destination register; 0 = no write
//  d_tnew       in   2  cycles from entering E until result forwardable (ALU 1, load 2, none 0)
//  d_md_start   in   1  D instruction starts mult/div
//  d_md_op      in   1  0 = mult, 1 = div (valid with d_md_start)
//  d_md_use     in   1  D instruction reads HI/LO or writes HI/LO (mfhi/mflo/mthi/mtlo)
//  stall        out  1  freeze PC and F/D, load NOP into D/E
//  fwd_d_a1/a2  out  2  D-stage operand select: 0 GRF, 1 E, 2 M, 3 W
//  fwd_e_a1/a2  out  2  E-stage operand select: 0 D/E reg value, 2 M, 3 W (1 never driven)
//  md_busy      out  1  MD unit executing
//  stall_cnt    out 32  stall cycles counted (HAZ_STAT_EN only)
// BEHAVIOUR
//  Reset (async, reset==0): E/M/W entries = NOP {a3=0,tnew=0,tuse=3,a1=0,a2=0}; md counter 0;
//   all outputs 0. Outputs combinational from state + D inputs, so first cycle after release: stall=0, fwd=0.
//  Shift each posedge: W<=M, M<=E, E<=(stall ? NOP : D). Tnew decrements on M<=E and W<=M,
//   saturating at 0 (never wraps to 3). Tuse not tracked past E.
//  Register 0: never matches, never stalls, never forwards.
//  Stall (comb.): for each D source s with tuse_s!=3, a_s!=0:
//   (E.a3==a_s && E.tnew>tuse_s) || (M.a3==a_s && M.tnew>tuse_s). W.tnew is always 0.
//  MD stall: (d_md_start|d_md_use) && (md_busy || E holds md_start). stall = OR of all terms.
//  D forward: youngest matching stage among E>M>W (a3==a_s, a3!=0); select it if its tnew==0,
//   else 0 (GRF; value corrected by E forward). No match -> 0.
//  E forward: same rule over M>W for E.a1/E.a2; stall guarantees the matching stage has tnew==0.
//  MD FSM IDLE/BUSY: on posedge where E holds md_start, load counter = MULT_CYC or DIV_CYC per E.md_op,
//   go BUSY. BUSY decrements each cycle; counter reaching 0 -> IDLE. md_busy = (state==BUSY).
//   MD state is never aborted by stall; an E-stage NOP never starts the unit.
//  Simultaneous: stall and counter expiry in same cycle -> counter still reaches 0, stall drops next cycle.
//  Reset mid-operation: MD counter and all stages cleared immediately, no residual stall.
// CONFIGURATION
//  HAZ_STAT_EN defined: stall_cnt increments each cycle stall==1, saturates at 32'hFFFF_FFFF,
//   cleared by reset. Undefined: stall_cnt tied to 0, no counter flops.
// TESTING
//  1 lw $1 then addu $2,$1,$1 (tuse 1): E.tnew=2>1 -> stall=1 one cycle; next cycle fwd_e_a1=3? no:
//    addu in D with lw in M tnew1=1 -> stall=0, then fwd_e_a1=fwd_e_a2=3 (W).
//  2 addu $3 then beq $3,$0 (tuse 0): stall=1 one cycle, then fwd_d_a1=2 (M, tnew 0).
//  3 addu $4 then sw data $4 (tuse 2): stall=0, fwd_d_a2=0, next cycle fwd_e_a2=2.
//  4 div (DIV_CYC=10) then mflo: md_busy=1 for 10 cycles; stall=1 until md_busy falls; with
//    HAZ_STAT_EN stall_cnt=11 (E-hold cycle + 10).
//  5 writes to $0 followed by readers of $0: stall=0, all fwd=0.
//  6 assert reset=0 mid-div: md_busy=0, stall=0, fwd=0 asynchronously; stall_cnt=0.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: D-stage stall, D/E forwarding selects, mult/div sequencing.
// Optional HAZ_STAT_EN: adds a saturating stall-cycle counter on stall_cnt (tied to 0 otherwise).
module hazard_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_a1,
    input  logic [4:0]  d_a2,
    input  logic [1:0]  d_tuse_a1,
    input  logic [1:0]  d_tuse_a2,
    input  logic [4:0]  d_a3,
    input  logic [1:0]  d_tnew,
    input  logic        d_md_start,
    input  logic        d_md_op,
    input  logic        d_md_use,
    output logic        stall,
    output logic [1:0]  fwd_d_a1,
    output logic [1:0]  fwd_d_a2,
    output logic [1:0]  fwd_e_a1,
    output logic [1:0]  fwd_e_a2,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // E stage keeps sources for E-forwarding; M and W only need destination and remaining Tnew
    logic [4:0] e_a1_q, e_a1_d;
    logic [4:0] e_a2_q, e_a2_d;
    logic [4:0] e_a3_q, e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic       e_md_start_q, e_md_start_d;
    logic       e_md_op_q, e_md_op_d;
    logic [4:0] m_a3_q, m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q, w_a3_d;
    logic [1:0] w_tnew_q, w_tnew_d;

    md_state_t   md_state_q, md_state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic haz_a1, haz_a2, haz_md;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse);
        logic h;
        h = 1'b0;
        if (tuse != 2'd3 && a != 5'd0) begin
            h = (e_a3_q == a && e_tnew_q > tuse) || (m_a3_q == a && m_tnew_q > tuse);
        end
        return h;
    endfunction

    // Youngest match wins; a match still in flight selects GRF and is fixed up by the E forward
    function automatic logic [1:0] sel_fwd_d(input logic [4:0] a);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != 5'd0) begin
            if (e_a3_q == a)      sel = (e_tnew_q == 2'd0) ? 2'd1 : 2'd0;
            else if (m_a3_q == a) sel = (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
            else if (w_a3_q == a) sel = (w_tnew_q == 2'd0) ? 2'd3 : 2'd0;
        end
        return sel;
    endfunction

    function automatic logic [1:0] sel_fwd_e(input logic [4:0] a);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != 5'd0) begin
            if (m_a3_q == a)      sel = (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
            else if (w_a3_q == a) sel = (w_tnew_q == 2'd0) ? 2'd3 : 2'd0;
        end
        return sel;
    endfunction

    always_comb begin
        haz_a1   = src_hazard(d_a1, d_tuse_a1);
        haz_a2   = src_hazard(d_a2, d_tuse_a2);
        haz_md   = (d_md_start | d_md_use) & ((md_state_q == MD_BUSY) | e_md_start_q);
        stall    = haz_a1 | haz_a2 | haz_md;
        fwd_d_a1 = sel_fwd_d(d_a1);
        fwd_d_a2 = sel_fwd_d(d_a2);
        fwd_e_a1 = sel_fwd_e(e_a1_q);
        fwd_e_a2 = sel_fwd_e(e_a2_q);
        md_busy  = (md_state_q == MD_BUSY);
    end

    always_comb begin
        e_a1_d       = '0;
        e_a2_d       = '0;
        e_a3_d       = '0;
        e_tnew_d     = '0;
        e_md_start_d = 1'b0;
        e_md_op_d    = 1'b0;
        if (!stall) begin
            e_a1_d       = d_a1;
            e_a2_d       = d_a2;
            e_a3_d       = d_a3;
            e_tnew_d     = d_tnew;
            e_md_start_d = d_md_start;
            e_md_op_d    = d_md_op;
        end
        m_a3_d   = e_a3_q;
        m_tnew_d = sat_dec(e_tnew_q);
        w_a3_d   = m_a3_q;
        w_tnew_d = sat_dec(m_tnew_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a1_q       <= '0;
            e_a2_q       <= '0;
            e_a3_q       <= '0;
            e_tnew_q     <= '0;
            e_md_start_q <= 1'b0;
            e_md_op_q    <= 1'b0;
            m_a3_q       <= '0;
            m_tnew_q     <= '0;
            w_a3_q       <= '0;
            w_tnew_q     <= '0;
        end else begin
            e_a1_q       <= e_a1_d;
            e_a2_q       <= e_a2_d;
            e_a3_q       <= e_a3_d;
            e_tnew_q     <= e_tnew_d;
            e_md_start_q <= e_md_start_d;
            e_md_op_q    <= e_md_op_d;
            m_a3_q       <= m_a3_d;
            m_tnew_q     <= m_tnew_d;
            w_a3_q       <= w_a3_d;
            w_tnew_q     <= w_tnew_d;
        end
    end

    // A start can only sit in E while the unit is idle, because D-side starts stall on md_busy
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            MD_IDLE: begin
                if (e_md_start_q) begin
                    md_cnt_d   = e_md_op_q ? CW'(DIV_CYC) : CW'(MULT_CYC);
                    md_state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - CW'(1);
                if (md_cnt_q == CW'(1)) begin
                    md_state_d = MD_IDLE;
                end
            end
            default: begin
                md_state_d = MD_IDLE;
                md_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

`ifdef HAZ_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: in-flight instruction model plus directed MIPS hazard sequences.
module tb_hazard_sched;

    logic        clk;
    logic        reset;
    logic [4:0]  d_a1, d_a2, d_a3;
    logic [1:0]  d_tuse_a1, d_tuse_a2, d_tnew;
    logic        d_md_start, d_md_op, d_md_use;
    logic        stall, md_busy;
    logic [1:0]  fwd_d_a1, fwd_d_a2, fwd_e_a1, fwd_e_a2;
    logic [31:0] stall_cnt;

    int npass  = 0;
    int ntotal = 0;
    bit run    = 0;

    hazard_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .d_a1(d_a1), .d_a2(d_a2), .d_tuse_a1(d_tuse_a1), .d_tuse_a2(d_tuse_a2),
        .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_op(d_md_op), .d_md_use(d_md_use),
        .stall(stall), .fwd_d_a1(fwd_d_a1), .fwd_d_a2(fwd_d_a2),
        .fwd_e_a1(fwd_e_a1), .fwd_e_a2(fwd_e_a2),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- model: instructions in flight, index 0=E, 1=M, 2=W ----------------
    typedef struct {
        int a1, a2, a3, tnew;
        bit mds, mdop;
    } rec_t;

    rec_t   pipe[3];
    longint cyc, md_t0, md_len, exp_cnt;

    function automatic int ready_in(int idx);
        return (pipe[idx].tnew > idx) ? pipe[idx].tnew - idx : 0;
    endfunction

    function automatic bit m_busy();
        return (cyc > md_t0) && (cyc <= md_t0 + md_len);
    endfunction

    function automatic bit m_stall();
        bit s;
        int a[2], tu[2];
        s = 0;
        a[0] = d_a1; a[1] = d_a2; tu[0] = d_tuse_a1; tu[1] = d_tuse_a2;
        for (int k = 0; k < 2; k++)
            if (tu[k] != 3 && a[k] != 0)
                for (int i = 0; i < 2; i++)
                    if (pipe[i].a3 == a[k] && ready_in(i) > tu[k]) s = 1;
        if ((d_md_start || d_md_use) && (m_busy() || pipe[0].mds)) s = 1;
        return s;
    endfunction

    function automatic int m_fwd(int a, int first);
        if (a == 0) return 0;
        for (int i = first; i < 3; i++)
            if (pipe[i].a3 == a) return (ready_in(i) == 0) ? i + 1 : 0;
        return 0;
    endfunction

    function automatic rec_t nop_rec();
        rec_t r;
        r.a1 = 0; r.a2 = 0; r.a3 = 0; r.tnew = 0; r.mds = 0; r.mdop = 0;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = nop_rec();
            cyc = 0; md_t0 = -100; md_len = 0; exp_cnt = 0;
        end else begin
            rec_t nr;
            bit   s;
            s = m_stall();
            if (s) exp_cnt++;
            if (pipe[0].mds) begin
                md_t0  = cyc;
                md_len = pipe[0].mdop ? 10 : 5;
            end
            nr = nop_rec();
            if (!s) begin
                nr.a1 = d_a1; nr.a2 = d_a2; nr.a3 = d_a3; nr.tnew = d_tnew;
                nr.mds = d_md_start; nr.mdop = d_md_op;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nr;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("stall", stall, m_stall());
            chk("md_busy", md_busy, m_busy());
            chk("fwd_d_a1", fwd_d_a1, m_fwd(d_a1, 0));
            chk("fwd_d_a2", fwd_d_a2, m_fwd(d_a2, 0));
            chk("fwd_e_a1", fwd_e_a1, m_fwd(pipe[0].a1, 1));
            chk("fwd_e_a2", fwd_e_a2, m_fwd(pipe[0].a2, 1));
`ifdef HAZ_STAT_EN
            chk("stall_cnt", stall_cnt, exp_cnt);
`else
            chk("stall_cnt", stall_cnt, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic setd(input int a1, input int tu1, input int a2, input int tu2,
                        input int a3, input int tn, input bit mds, input bit mop, input bit mdu);
        d_a1 = 5'(a1); d_tuse_a1 = 2'(tu1); d_a2 = 5'(a2); d_tuse_a2 = 2'(tu2);
        d_a3 = 5'(a3); d_tnew = 2'(tn);
        d_md_start = mds; d_md_op = mop; d_md_use = mdu;
    endtask

    task automatic setnop();
        setd(0, 3, 0, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the D instruction until it leaves D (bounded)
    task automatic issue(input int a1, input int tu1, input int a2, input int tu2,
                         input int a3, input int tn, input bit mds, input bit mop, input bit mdu);
        int  n;
        bit  st;
        setd(a1, tu1, a2, tu2, a3, tn, mds, mop, mdu);
        n = 0;
        do begin
            @(negedge clk);
            st = stall;
            step();
            n++;
        end while (st && n < 40);
        if (st) chk("issue_timeout", 1, 0);
    endtask

    typedef struct {
        int a1, tu1, a2, tu2, a3, tn;
        bit mds, mop, mdu;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        setnop();
        #1 reset = 1'b0;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_fwd_d_a1", fwd_d_a1, 0);
        chk("rst_fwd_e_a2", fwd_e_a2, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        run = 1;
        step(); step();

        // 1: lw $1 ; addu $2,$1,$1
        setd(29, 1, 0, 3, 1, 2, 0, 0, 0);
        step();
        setd(1, 1, 1, 1, 2, 1, 0, 0, 0);
        #1 chk("t1_stall", stall, 1);
        step();
        chk("t1_nostall", stall, 0);
        chk("t1_fwd_d_a1", fwd_d_a1, 0);
        step();
        setnop();
        #1;
        chk("t1_fwd_e_a1", fwd_e_a1, 3);
        chk("t1_fwd_e_a2", fwd_e_a2, 3);

        // 2: addu $3 ; beq $3,$0
        setd(10, 1, 11, 1, 3, 1, 0, 0, 0);
        step();
        setd(3, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2_stall", stall, 1);
        step();
        chk("t2_nostall", stall, 0);
        chk("t2_fwd_d_a1", fwd_d_a1, 2);
        setnop();
        step();

        // 3: addu $4 ; sw $4,0($5)
        setd(12, 1, 13, 1, 4, 1, 0, 0, 0);
        step();
        setd(5, 1, 4, 2, 0, 0, 0, 0, 0);
        #1;
        chk("t3_stall", stall, 0);
        chk("t3_fwd_d_a2", fwd_d_a2, 0);
        step();
        setnop();
        #1;
        chk("t3_fwd_e_a2", fwd_e_a2, 2);
        chk("t3_fwd_e_a1", fwd_e_a1, 0);
        step(); step(); step();

        // 4: div ; mflo
        setd(6, 1, 7, 1, 0, 0, 1, 1, 0);
        step();
        setd(0, 3, 0, 3, 8, 1, 0, 0, 1);
        #1;
        chk("t4_hold_stall", stall, 1);
        chk("t4_hold_busy", md_busy, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_busy", md_busy, 1);
            chk("t4_busy_stall", stall, 1);
        end
        step();
        chk("t4_done_busy", md_busy, 0);
        chk("t4_done_stall", stall, 0);
`ifdef HAZ_STAT_EN
        chk("t4_stall_cnt", stall_cnt, 13);
`else
        chk("t4_stall_cnt", stall_cnt, 0);
`endif
        setnop();
        step();

        // mult ; mult ; mfhi
        issue(6, 1, 7, 1, 0, 0, 1, 0, 0);
        issue(8, 1, 9, 1, 0, 0, 1, 0, 0);
        issue(0, 3, 0, 3, 10, 1, 0, 0, 1);
        setnop();
        for (int i = 0; i < 8; i++) step();

        // 5: writes to $0 followed by readers of $0
        setd(1, 1, 2, 1, 0, 1, 0, 0, 0);
        step();
        setd(29, 1, 0, 3, 0, 2, 0, 0, 0);
        step();
        setd(0, 0, 0, 0, 9, 1, 0, 0, 0);
        #1;
        chk("t5_stall", stall, 0);
        chk("t5_fwd_d_a1", fwd_d_a1, 0);
        chk("t5_fwd_d_a2", fwd_d_a2, 0);
        step();
        setnop();
        #1;
        chk("t5_fwd_e_a1", fwd_e_a1, 0);
        chk("t5_fwd_e_a2", fwd_e_a2, 0);

        // directed table: load-use chains, mixed Tuse, mult/div interleave
        tbl[0]  = '{29, 1, 0, 3, 7, 2, 0, 0, 0};
        tbl[1]  = '{7, 0, 0, 3, 0, 0, 0, 0, 0};
        tbl[2]  = '{7, 1, 7, 1, 11, 1, 0, 0, 0};
        tbl[3]  = '{11, 2, 11, 2, 12, 1, 0, 0, 0};
        tbl[4]  = '{12, 1, 11, 0, 13, 2, 0, 0, 0};
        tbl[5]  = '{13, 1, 12, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{13, 0, 0, 3, 14, 1, 0, 0, 1};
        tbl[7]  = '{14, 1, 14, 2, 15, 2, 0, 0, 0};
        tbl[8]  = '{15, 1, 14, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 3, 0, 3, 0, 0, 1, 1, 0};
        tbl[10] = '{15, 1, 0, 3, 16, 1, 0, 0, 0};
        tbl[11] = '{16, 0, 15, 0, 0, 0, 0, 0, 1};
        foreach (tbl[i])
            issue(tbl[i].a1, tbl[i].tu1, tbl[i].a2, tbl[i].tu2, tbl[i].a3, tbl[i].tn,
                  tbl[i].mds, tbl[i].mop, tbl[i].mdu);
        setnop();
        for (int i = 0; i < 14; i++) step();

        // 6: reset in the middle of a div
        setd(6, 1, 7, 1, 0, 0, 1, 1, 0);
        step();
        setd(0, 3, 0, 3, 8, 1, 0, 0, 1);
        step(); step(); step();
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", md_busy, 0);
        chk("t6_stall", stall, 0);
        chk("t6_fwd_d_a1", fwd_d_a1, 0);
        chk("t6_fwd_e_a1", fwd_e_a1, 0);
        chk("t6_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("t6_release_stall", stall, 0);
        step();
        chk("t6_after_busy", md_busy, 0);
        setnop();
        step(); step();

        run = 0;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
